qie_frame_rx: RTL and testbench

- FPGA front-end receiver that consumes the 8-bit byte stream driven by one QIE channel model/chip (Qie_Out with its byte strobe) and rebuilds per-bunch-crossing frames.
- Aligns byte pairs using the CapID rotation, decodes the ADC/TDC/CapID fields and tracks link errors.
- Its outputs feed the FPGA's per-channel data path: a one-cycle frame strobe plus decoded fields.
- Twelve instances sit in the FPGA top, one per QIE channel.

---
 rtl/qie_frame_rx_if.sv | 21 ++
 rtl/qie_frame_rx.sv | 97 +++++++++
 tb/tb_qie_frame_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/qie_frame_rx_if.sv
// qie_frame_rx_if: QIE byte stream in, decoded per-crossing frame out
//   master: drives qie_byte/qie_byte_valid/qie_disc, receives decoded outputs
//   slave : receiver side (qie_frame_rx)
interface qie_frame_rx_if #(parameter int ERR_CNT_W = 16);
  logic [7:0]           qie_byte;
  logic                 qie_byte_valid;
  logic                 qie_disc;
  logic                 frame_valid;
  logic [5:0]           adc_mant;
  logic [1:0]           adc_exp;
  logic [5:0]           tdc;
  logic [1:0]           cap_id;
  logic                 disc;
  logic                 capid_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;
  modport master(output qie_byte, qie_byte_valid, qie_disc,
                 input frame_valid, adc_mant, adc_exp, tdc, cap_id, disc, capid_err, locked, err_count);
  modport slave(input qie_byte, qie_byte_valid, qie_disc,
                output frame_valid, adc_mant, adc_exp, tdc, cap_id, disc, capid_err, locked, err_count);
endinterface

// File: rtl/qie_frame_rx.sv
// qie_frame_rx: aligns QIE byte pairs on CapID rotation and decodes ADC/TDC/CapID frames
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): qie_byte/qie_byte_valid/qie_disc in; frame_valid, adc_mant, adc_exp,
//                tdc, cap_id, disc, capid_err, locked, err_count out (all registered)
module qie_frame_rx #(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int ERR_CNT_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  qie_frame_rx_if.slave  bus
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [7:0] LF = 8'(LOCK_FRAMES);
  localparam logic [7:0] UE = 8'(UNLOCK_ERRS);
  state_t     r_state;
  logic       r_phase;
  logic [7:0] r_a;
  logic [1:0] r_exp;
  logic [7:0] r_good;
  logic [7:0] r_bad;
  logic [1:0] w_cap;
  logic       w_match;
  assign w_cap   = bus.qie_byte[7:6];
  assign w_match = w_cap == r_exp;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= HUNT;
      r_phase         <= 1'b0;
      r_a             <= '0;
      r_exp           <= '0;
      r_good          <= '0;
      r_bad           <= '0;
      bus.frame_valid <= 1'b0;
      bus.adc_mant    <= '0;
      bus.adc_exp     <= '0;
      bus.tdc         <= '0;
      bus.cap_id      <= '0;
      bus.disc        <= 1'b0;
      bus.capid_err   <= 1'b0;
      bus.locked      <= 1'b0;
      bus.err_count   <= '0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.capid_err   <= 1'b0;
      if (bus.qie_byte_valid && !r_phase) begin
        r_a     <= bus.qie_byte;
        r_phase <= 1'b1;
      end else if (bus.qie_byte_valid) begin
        r_phase <= 1'b0;
        r_exp   <= w_cap + 2'd1;
        case (r_state)
          HUNT: begin
            r_good  <= '0;
            r_state <= VERIFY;
          end
          VERIFY: begin
            if (w_match) begin
              r_good <= r_good + 8'd1;
              if (r_good + 8'd1 == LF) begin
                r_state    <= LOCKED;
                r_bad      <= '0;
                bus.locked <= 1'b1;
              end
            end else begin
              // slip: current byte becomes byte A of the next frame
              r_state <= HUNT;
              r_a     <= bus.qie_byte;
              r_phase <= 1'b1;
            end
          end
          default: begin
            bus.frame_valid <= 1'b1;
            bus.adc_mant    <= r_a[5:0];
            bus.adc_exp     <= r_a[7:6];
            bus.tdc         <= bus.qie_byte[5:0];
            bus.cap_id      <= w_cap;
            bus.disc        <= bus.qie_disc;
            if (w_match) r_bad <= '0;
            else begin
              bus.capid_err <= 1'b1;
              r_bad         <= r_bad + 8'd1;
              if (~&bus.err_count) bus.err_count <= bus.err_count + ERR_CNT_W'(1);
              if (r_bad + 8'd1 == UE) begin
                r_state    <= HUNT;
                r_a        <= bus.qie_byte;
                r_phase    <= 1'b1;
                bus.locked <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qie_frame_rx.sv
// tb_qie_frame_rx: randomized self-checking bench for qie_frame_rx against a frame-level model
module tb_qie_frame_rx;
  localparam int EW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  qie_frame_rx_if #(.ERR_CNT_W(EW)) bus();
  qie_frame_rx #(.LOCK_FRAMES(4), .UNLOCK_ERRS(3), .ERR_CNT_W(EW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int m_st, m_ph, m_a, m_exp, m_good, m_bad, m_err;
  int e_fv, e_cerr, e_lock, e_mant, e_exp, e_tdc, e_cap, e_disc;
  int n_chk = 0, n_fail = 0, n_cerr = 0;
  int cap;
  bit gaps = 1'b0;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // frame-level reference: mode 0 hunting, 1 verifying, 2 locked
  task automatic model(bit r, bit v, int b, bit d);
    int c;
    bit slip;
    if (r) begin
      m_st = 0; m_ph = 0; m_a = 0; m_exp = 0; m_good = 0; m_bad = 0; m_err = 0;
      e_fv = 0; e_cerr = 0; e_lock = 0; e_mant = 0; e_exp = 0; e_tdc = 0; e_cap = 0; e_disc = 0;
      return;
    end
    e_fv = 0;
    e_cerr = 0;
    if (!v) return;
    if (m_ph == 0) begin
      m_a = b;
      m_ph = 1;
      return;
    end
    c = b / 64;
    slip = 0;
    m_ph = 0;
    if (m_st == 2) begin
      e_fv = 1; e_mant = m_a % 64; e_exp = m_a / 64; e_tdc = b % 64; e_cap = c; e_disc = int'(d);
      if (c == m_exp) m_bad = 0;
      else begin
        e_cerr = 1;
        if (m_err < 2 ** EW - 1) m_err++;
        m_bad++;
        if (m_bad == 3) begin slip = 1; e_lock = 0; m_st = 0; end
      end
    end else if (m_st == 1) begin
      if (c == m_exp) begin
        m_good++;
        if (m_good == 4) begin m_st = 2; e_lock = 1; m_bad = 0; end
      end else begin
        slip = 1;
        m_st = 0;
      end
    end else begin
      m_good = 0;
      m_st = 1;
    end
    m_exp = (c + 1) % 4;
    if (slip) begin m_a = b; m_ph = 1; end
  endtask
  task automatic cyc(bit r, bit v, logic [7:0] b, bit d);
    logic [15:0] e_fields;
    reset = r;
    bus.qie_byte_valid = v;
    bus.qie_byte = b;
    bus.qie_disc = d;
    @(posedge clk);
    model(r, v, int'(b), d);
    #1;
    chk("frame_valid", int'(bus.frame_valid), e_fv);
    chk("capid_err", int'(bus.capid_err), e_cerr);
    chk("locked", int'(bus.locked), e_lock);
    chk("err_count", int'(bus.err_count), m_err);
    if (e_fv == 1) begin
      e_fields = {e_mant[5:0], e_exp[1:0], e_tdc[5:0], e_cap[1:0]};
      chk("fields", int'({bus.adc_mant, bus.adc_exp, bus.tdc, bus.cap_id}), int'(e_fields));
      chk("disc", int'(bus.disc), e_disc);
    end
    if (bus.capid_err) n_cerr++;
  endtask
  task automatic gap();
    if (gaps) while ($urandom_range(1, 0) == 1) cyc(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask
  task automatic send_frame(int c, int mant, int ex, int t, bit d);
    logic [7:0] ba, bb;
    ba = {ex[1:0], mant[5:0]};
    bb = {c[1:0], t[5:0]};
    gap();
    cyc(1'b0, 1'b1, ba, 1'b0);
    gap();
    cyc(1'b0, 1'b1, bb, d);
  endtask
  // good frame with the next CapID; ex < 0 randomizes the exponent
  task automatic good(int ex);
    send_frame(cap, int'($urandom_range(63, 0)), ex < 0 ? int'($urandom_range(3, 0)) : ex,
               int'($urandom_range(63, 0)), 1'($urandom));
    cap = (cap + 1) % 4;
  endtask
  task automatic glitch();
    int s;
    s = (cap + 2) % 4;
    send_frame(s, int'($urandom_range(63, 0)), 0, int'($urandom_range(63, 0)), 1'($urandom));
    cap = (s + 1) % 4;
  endtask
  task automatic chk_all_zero(string tag);
    chk(tag, int'({bus.frame_valid, bus.adc_mant, bus.adc_exp, bus.tdc, bus.cap_id, bus.disc,
                   bus.capid_err, bus.locked, bus.err_count}), 0);
  endtask
  initial begin
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'hff, 1'b1);
    chk_all_zero("reset_outputs");
    cap = 1;
    send_frame(1, 'h14, 1, 6, 1'b1);
    cap = 2;
    for (int k = 2; k <= 12; k++) begin
      good(-1);
      if (k == 4) chk("lock_before_f5", int'(bus.locked), 0);
      if (k == 5) chk("lock_at_f5", int'(bus.locked), 1);
      if (k == 5) chk("no_fv_at_f5", int'(bus.frame_valid), 0);
      if (k == 6) chk("fv_at_f6", int'(bus.frame_valid), 1);
    end
    chk("aligned_err", int'(bus.err_count), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    n_cerr = 0;
    cyc(1'b0, 1'b1, 8'h3c, 1'b0);
    cap = 1;
    for (int k = 0; k < 20; k++) good(0);
    chk("stray_locked", int'(bus.locked), 1);
    chk("stray_no_cerr", n_cerr, 0);
    n_cerr = 0;
    for (int k = 0; k < 3; k++) good(-1);
    glitch();
    for (int k = 0; k < 5; k++) good(-1);
    chk("glitch_cerr_cnt", n_cerr, 1);
    chk("glitch_err_count", int'(bus.err_count), 1);
    chk("glitch_locked", int'(bus.locked), 1);
    n_cerr = 0;
    for (int k = 0; k < 3; k++) begin
      glitch();
      chk("bad3_locked", int'(bus.locked), k < 2 ? 1 : 0);
    end
    for (int k = 0; k < 10; k++) good(0);
    chk("bad3_cerr_cnt", n_cerr, 3);
    chk("bad3_relock", int'(bus.locked), 1);
    for (int k = 0; k < 20; k++) begin
      glitch();
      good(-1);
      good(-1);
    end
    chk("sat_err_count", int'(bus.err_count), 15);
    chk("sat_locked", int'(bus.locked), 1);
    gaps = 1'b1;
    for (int k = 0; k < 12; k++) good(-1);
    chk("gap_locked", int'(bus.locked), 1);
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    gap();
    cyc(1'b1, 1'b1, 8'h9a, 1'b1);
    chk_all_zero("midframe_reset");
    cap = 1;
    for (int k = 0; k < 15; k++) good(0);
    chk("gap_relock", int'(bus.locked), 1);
    chk("gap_relock_err", int'(bus.err_count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
